uart_sample_scheduler: RTL
==========================

// Module: uart_sample_scheduler
// PURPOSE
//  Shares one byte-wide UART transmitter between the single-mic (beamformed) and dual-mic (raw) streams.
//  Queues whole sample frames in a small FIFO and applies dual-mode decimation.
//  Serialises each frame little-endian into the transmitter's trigger/busy handshake.
//  Sits in the clk_100mhz domain between the audio/DSS outputs and a 1-byte uart transmitter.
// PARAMETERS
//  SAMPLE_WIDTH  16  bits per channel sample (multiple of 8)
//  NUM_CH        2   channels carried in a dual-mode frame
//  FIFO_DEPTH    4   frames buffered (power of 2, >=2)
//  DECIMATE      2   dual mode: one frame pushed per DECIMATE accepted samples
// PORTS
//  clk_in             in   1                     system clock (100 MHz)
//  rst_in             in   1                     synchronous, active-high reset
//  enable_in          in   1                     1 = accept new samples
//  mode_in            in   1                     0 = single (ch0 only), 1 = dual (all NUM_CH)
//  sample_valid_in    in   1                     1-cycle pulse, new sample set present
//  sample_in          in   NUM_CH*SAMPLE_WIDTH   ch k at [k*SAMPLE_WIDTH +: SAMPLE_WIDTH]
//  tx_busy_in         in   1                     transmitter busy (high cycle after trigger until byte done)
//  tx_byte_out        out  8                     byte to transmit, stable while tx_trigger_out high
//  tx_trigger_out     out  1                     1-cycle start pulse to transmitter
//  fifo_level_out     out  $clog2(FIFO_DEPTH)+1  frames queued
//  overflow_out       out  1                     sticky: a frame was dropped
//  drop_count_out     out  16                    dropped frames, saturates at 16'hFFFF
// BEHAVIOUR
//  Reset: all outputs 0, FIFO empty, FSM IDLE, decimation counter 0; reset mid-frame abandons it (no more bytes).
//  Push: on sample_valid_in && enable_in:
//   - mode_in=0: push {mode=0, sample_in}.
//   - mode_in=1: push only when dec_cnt==0; dec_cnt increments mod DECIMATE on each accepted valid.
//   - dec_cnt forced to 0 on any cycle with mode_in=0.
//   - Frame tagged with mode_in sampled in the push cycle.
//  Full: push while full and no pop in that cycle -> frame dropped, overflow_out<=1, drop_count_out+1 (sat).
//   - Push and pop in the same cycle when full: push accepted, level unchanged.
//  enable_in=0: no pushes and no drops counted; queued frames and an in-flight frame still drain.
//  FSM: IDLE -> LOAD -> SEND -> HOLD -> WAIT -> (SEND | IDLE).
//   - IDLE: FIFO non-empty -> LOAD.
//   - LOAD: pop head into shift reg; bytes_left = SAMPLE_WIDTH/8 (mode 0) or NUM_CH*SAMPLE_WIDTH/8 (mode 1); -> SEND.
//   - SEND: if !tx_busy_in, drive tx_trigger_out=1 for exactly 1 cycle, tx_byte_out = shift[7:0]; -> HOLD.
//     Otherwise stay in SEND.
//   - HOLD: 1 cycle, tx_busy_in ignored (covers transmitter busy latency); shift right 8; bytes_left-1; -> WAIT.
//   - WAIT: tx_busy_in=0 -> SEND if bytes_left>0, else IDLE.
//  Byte order: ch0 low byte, ch0 high byte, ch1 low, ch1 high, ... (equals {chN..ch0} LSB-first).
//  Latency: valid pulse at cycle t, empty FIFO, busy low -> tx_trigger_out high at cycle t+3.
//  Mode change mid-frame: in-flight and queued frames keep their own tag and byte count.
//  tx_trigger_out is never high in two consecutive cycles.
//  A frame is never split or interleaved with another frame.
//  fifo_level_out updates the cycle after a push or pop.
// TESTING
//  - Single mode, busy modelled 10 cycles/byte, ch0=16'h1234 -> bytes 34,12; ch1 never sent.
//  - Dual mode, DECIMATE=2, 4 valids ch0=A0+i, ch1=B0+i (i=0..3) -> frames i=0,2 only: bytes A0,00,B0,00 then A2,00,B2,00.
//  - tx_busy_in held high, 7 single-mode valids -> level=4, frame 1 in shift reg.
//    -> 2 drops: drop_count_out=2, overflow_out=1.
//    -> release busy: 5 frames sent in push order.
//  - Reset asserted after 1st byte of dual frame -> trigger stays 0, level=0, counters 0, no further bytes.
//  - Queue single frame then switch mode_in=1 before pop -> 2 bytes sent; next dual frame sends 4 bytes.
//  - enable_in=0 with 2 frames queued, 5 valids -> both frames drain; no pushes; drop_count_out unchanged.

Source files
------------

// File: rtl/uart_sample_scheduler.sv
// uart_sample_scheduler: queues single/dual-mic sample frames and serialises
// them little-endian, one frame at a time, into a byte-wide UART transmitter.
module uart_sample_scheduler #(
  parameter int unsigned SAMPLE_WIDTH = 16,
  parameter int unsigned NUM_CH       = 2,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned DECIMATE     = 2
) (
  input  logic                             clk_in,
  input  logic                             rst_in,
  input  logic                             enable_in,
  input  logic                             mode_in,
  input  logic                             sample_valid_in,
  input  logic [NUM_CH*SAMPLE_WIDTH-1:0]   sample_in,
  input  logic                             tx_busy_in,
  output logic [7:0]                       tx_byte_out,
  output logic                             tx_trigger_out,
  output logic [$clog2(FIFO_DEPTH):0]      fifo_level_out,
  output logic                             overflow_out,
  output logic [15:0]                      drop_count_out
);

  localparam int unsigned DATA_W       = NUM_CH * SAMPLE_WIDTH;
  localparam int unsigned PTR_W        = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W        = PTR_W + 1;
  localparam int unsigned BYTES_SINGLE = SAMPLE_WIDTH / 8;
  localparam int unsigned BYTES_DUAL   = DATA_W / 8;
  localparam int unsigned CNT_W        = $clog2(BYTES_DUAL + 1);
  localparam int unsigned DEC_W        = (DECIMATE > 1) ? $clog2(DECIMATE) : 1;

  typedef struct packed {
    logic              mode;
    logic [DATA_W-1:0] data;
  } frame_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_HOLD,
    S_WAIT
  } state_t;

  state_t             state_q, state_d;
  frame_t             mem_q [FIFO_DEPTH];
  frame_t             mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic [DEC_W-1:0]   dec_cnt_q, dec_cnt_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic [CNT_W-1:0]   bytes_left_q, bytes_left_d;
  logic               overflow_q, overflow_d;
  logic [15:0]        drop_q, drop_d;

  logic accept_c;
  logic push_req_c;
  logic pop_c;
  logic full_c;
  logic push_c;
  logic drop_c;

  // Push/drop decision, decimation counter, FIFO storage and drop statistics.
  always_comb begin
    accept_c   = sample_valid_in && enable_in;
    push_req_c = accept_c && (!mode_in || (dec_cnt_q == '0));
    pop_c      = (state_q == S_LOAD);
    full_c     = (level_q == LVL_W'(FIFO_DEPTH));
    push_c     = push_req_c && (!full_c || pop_c);
    drop_c     = push_req_c && full_c && !pop_c;

    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    dec_cnt_d  = dec_cnt_q;
    overflow_d = overflow_q;
    drop_d     = drop_q;

    if (!mode_in) begin
      dec_cnt_d = '0;
    end else if (accept_c) begin
      dec_cnt_d = (dec_cnt_q == DEC_W'(DECIMATE - 1)) ? '0 : dec_cnt_q + DEC_W'(1);
    end

    if (push_c) begin
      mem_d[wr_ptr_q] = '{mode: mode_in, data: sample_in};
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    case ({push_c, pop_c})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    if (drop_c) begin
      overflow_d = 1'b1;
      if (drop_q != 16'hFFFF) begin
        drop_d = drop_q + 16'd1;
      end
    end
  end

  // Frame serialiser: load head frame, then one trigger/hold/wait round per byte.
  always_comb begin
    state_d        = state_q;
    shift_d        = shift_q;
    bytes_left_d   = bytes_left_q;
    tx_trigger_out = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (level_q != '0) begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        shift_d      = mem_q[rd_ptr_q].data;
        bytes_left_d = mem_q[rd_ptr_q].mode ? CNT_W'(BYTES_DUAL) : CNT_W'(BYTES_SINGLE);
        state_d      = S_SEND;
      end
      S_SEND: begin
        if (!tx_busy_in) begin
          tx_trigger_out = 1'b1;
          state_d        = S_HOLD;
        end
      end
      S_HOLD: begin
        // Transmitter raises busy one cycle late, so busy is not looked at here.
        shift_d      = shift_q >> 8;
        bytes_left_d = bytes_left_q - CNT_W'(1);
        state_d      = S_WAIT;
      end
      S_WAIT: begin
        if (!tx_busy_in) begin
          state_d = (bytes_left_q != '0) ? S_SEND : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= S_IDLE;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      dec_cnt_q    <= '0;
      shift_q      <= '0;
      bytes_left_q <= '0;
      overflow_q   <= 1'b0;
      drop_q       <= '0;
    end else begin
      state_q      <= state_d;
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      dec_cnt_q    <= dec_cnt_d;
      shift_q      <= shift_d;
      bytes_left_q <= bytes_left_d;
      overflow_q   <= overflow_d;
      drop_q       <= drop_d;
    end
  end

  assign tx_byte_out    = shift_q[7:0];
  assign fifo_level_out = level_q;
  assign overflow_out   = overflow_q;
  assign drop_count_out = drop_q;

endmodule
